// File: rtl/ntt_mem_pkg.sv
// Shared definitions for the banked memory.
//   clr_state_e : state encoding of the shared clear sweep FSM
//   RD_LAT_MIN / RD_LAT_MAX : legal range of the bank read latency
package ntt_mem_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_bank.sv
// One memory bank: a simple dual-port array (one write port, one read
// port) followed by an RD_LAT-stage read pipeline.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (pipeline only, not the array)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read request
//   rd_addr  : read address
//   rd_data  : read data, RD_LAT cycles after rd_en, held between reads
//   rd_valid : one-cycle qualifier for rd_data
module mem_bank
    import ntt_mem_pkg::*;
#(
    parameter int DW     = 32,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    logic [DW-1:0]     mem_r [DEPTH];
    logic [DW-1:0]     pipe_data_r [RD_LAT];
    logic [RD_LAT-1:0] pipe_vld_r;

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read pipeline. The array is sampled with a non-blocking read, so a
    // same-edge write to the same address is not seen (read-first). Data
    // stages only load when the stage ahead holds a valid word, so the
    // output keeps its last value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_r <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_data_r[k] <= '0;
            end
        end else begin
            pipe_vld_r[0] <= rd_en;
            if (rd_en) begin
                pipe_data_r[0] <= mem_r[rd_addr];
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld_r[k] <= pipe_vld_r[k-1];
                if (pipe_vld_r[k-1]) begin
                    pipe_data_r[k] <= pipe_data_r[k-1];
                end
            end
        end
    end

    assign rd_data  = pipe_data_r[RD_LAT-1];
    assign rd_valid = pipe_vld_r[RD_LAT-1];

endmodule

// File: rtl/banked_memory.sv
// NBANKS independent dual-port memory banks with a shared clear sweep.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset; starts a clear sweep
//   we/waddr/din   : per-bank write port (dropped while clr_busy)
//   re/raddr       : per-bank read request
//   dout/dout_valid: per-bank read result, RD_LAT cycles after re
//   clr_start  : one-cycle request to zero every bank (ignored while busy)
//   clr_busy   : high while the sweep is running
//   clr_done   : one-cycle pulse in the cycle after the last zero write
module banked_memory
    import ntt_mem_pkg::*;
#(
    parameter int  NBANKS = 257,
    parameter int  DW     = 32,
    parameter int  DEPTH  = 256,
    parameter int  RD_LAT = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NBANKS-1:0]            we,
    input  logic [NBANKS-1:0][AW-1:0]    waddr,
    input  logic [NBANKS-1:0][DW-1:0]    din,
    input  logic [NBANKS-1:0]            re,
    input  logic [NBANKS-1:0][AW-1:0]    raddr,
    output logic [NBANKS-1:0][DW-1:0]    dout,
    output logic [NBANKS-1:0]            dout_valid,
    input  logic                         clr_start,
    output logic                         clr_busy,
    output logic                         clr_done
);

    if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
        $error("banked_memory: RD_LAT out of range");
    end

    clr_state_e    state_r;
    clr_state_e    state_s;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_s;
    logic          done_r;
    logic          done_s;
    logic          busy_s;

    // Clear FSM registers; reset lands directly in CLEAR so memory is
    // zeroed automatically once reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CLEAR;
            cnt_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            done_r  <= done_s;
        end
    end

    // Clear FSM next state: one address per cycle, back to 0 at the end.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (clr_start) begin
                    state_s = CLEAR;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                // clr_start is not examined here: no restart or extension.
                if (cnt_r == AW'(DEPTH - 1)) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s   = cnt_r + AW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    assign busy_s   = (state_r == CLEAR);
    assign clr_busy = busy_s;
    assign clr_done = done_r;

    for (genvar i = 0; i < NBANKS; i++) begin : g_bank
        logic          wr_en_s;
        logic [AW-1:0] wr_addr_s;
        logic [DW-1:0] wr_data_s;

        // During the sweep the write port belongs to the clear counter and
        // user writes are dropped.
        assign wr_en_s   = busy_s ? 1'b1  : we[i];
        assign wr_addr_s = busy_s ? cnt_r : waddr[i];
        assign wr_data_s = busy_s ? '0    : din[i];

        mem_bank #(
            .DW     (DW),
            .DEPTH  (DEPTH),
            .RD_LAT (RD_LAT),
            .AW     (AW)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en_s),
            .wr_addr  (wr_addr_s),
            .wr_data  (wr_data_s),
            .rd_en    (re[i]),
            .rd_addr  (raddr[i]),
            .rd_data  (dout[i]),
            .rd_valid (dout_valid[i])
        );
    end

endmodule
